// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// Shares one iterative 64-bit signed divider among NUM_REQ issue ports.
// Requests are picked round-robin, the divider is started with a single
// div_valid_in pulse, and its quotient is returned with the operation's tag
// over a ready/valid result port. Divide-by-zero and the one signed overflow
// case (most-negative / -1) are answered directly without using the divider.
// A flush kills whatever is pending or in flight; an operation already
// started in the divider runs to completion and its quotient is dropped.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           discard all pending and in-flight work
//   req_valid/ready per-port request handshake (NUM_REQ bits)
//   req_dividend    packed per-port dividends, port i at [64i+63:64i]
//   req_divisor     packed per-port divisors, same packing
//   req_tag         packed per-port tags, port i at [TAG_W*i +: TAG_W]
//   res_valid/ready result handshake toward writeback
//   res_quotient    signed quotient
//   res_tag         tag of the returned result
//   busy            controller is not idle
//   div_dividend    operand to the divider (held from capture)
//   div_divisor     operand to the divider (held from capture)
//   div_valid_in    one-cycle start pulse to the divider
//   div_quotient    quotient from the divider
//   div_valid_out   one-cycle completion pulse from the divider
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*64-1:0]    req_dividend,
   input  logic [NUM_REQ*64-1:0]    req_divisor,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [63:0]              res_quotient,
   output logic [TAG_W-1:0]         res_tag,
   output logic                     busy,
   output logic [63:0]              div_dividend,
   output logic [63:0]              div_divisor,
   output logic                     div_valid_in,
   input  logic [63:0]              div_quotient,
   input  logic                     div_valid_out
);

   localparam int          PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [63:0]        op_dvd;
   logic [63:0]        op_dvd_next;
   logic [63:0]        op_dvs;
   logic [63:0]        op_dvs_next;
   logic [TAG_W-1:0]   op_tag;
   logic [TAG_W-1:0]   op_tag_next;
   logic [63:0]        result;
   logic [63:0]        result_next;
   logic               drop;
   logic               drop_next;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_next;

   logic               res_valid_q;
   logic               busy_q;
   logic               issue_q;

   logic               grant_found;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   cand;

   logic [63:0]        dvd_arr [NUM_REQ];
   logic [63:0]        dvs_arr [NUM_REQ];
   logic [TAG_W-1:0]   tag_arr [NUM_REQ];

   // Unpack the flat per-port buses so the granted port can be selected by
   // index rather than by a computed part-select.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign dvd_arr[i] = req_dividend[64*i +: 64];
      assign dvs_arr[i] = req_divisor[64*i +: 64];
      assign tag_arr[i] = req_tag[TAG_W*i +: TAG_W];
   end

   // Round-robin search: start one past the last granted port and take the
   // first one with a valid request, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Next-state and next-datapath logic. req_ready is the only output
   // produced here; everything else toward the outside comes from flops.
   always_comb begin
      state_next  = state;
      op_dvd_next = op_dvd;
      op_dvs_next = op_dvs;
      op_tag_next = op_tag;
      result_next = result;
      drop_next   = drop;
      ptr_next    = ptr;
      req_ready   = '0;

      case (state)
         IDLE: begin
            if (!flush && grant_found) begin
               req_ready[grant_idx] = 1'b1;
               op_dvd_next          = dvd_arr[grant_idx];
               op_dvs_next          = dvs_arr[grant_idx];
               op_tag_next          = tag_arr[grant_idx];
               ptr_next             = grant_idx;
               // The two cases the divider cannot answer meaningfully are
               // resolved here and go straight to the response state.
               if (dvs_arr[grant_idx] == 64'd0) begin
                  result_next = ALL_ONES;
                  state_next  = RESP;
               end else if (dvd_arr[grant_idx] == MOST_NEG &&
                            dvs_arr[grant_idx] == ALL_ONES) begin
                  result_next = MOST_NEG;
                  state_next  = RESP;
               end else begin
                  state_next = ISSUE;
               end
            end
         end

         ISSUE: begin
            // The start pulse cannot be withdrawn, so a flush here only
            // marks the eventual quotient for discard.
            if (flush) begin
               drop_next = 1'b1;
            end
            state_next = BUSY;
         end

         BUSY: begin
            if (div_valid_out) begin
               if (drop || flush) begin
                  drop_next  = 1'b0;
                  state_next = IDLE;
               end else begin
                  result_next = div_quotient;
                  state_next  = RESP;
               end
            end else if (flush) begin
               drop_next = 1'b1;
            end
         end

         RESP: begin
            if (flush || res_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers. The externally visible strobes are
   // registered from the next state so they come straight off flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_dvd      <= '0;
         op_dvs      <= '0;
         op_tag      <= '0;
         result      <= '0;
         drop        <= 1'b0;
         ptr         <= PTR_W'(NUM_REQ - 1);
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         issue_q     <= 1'b0;
      end else begin
         state       <= state_next;
         op_dvd      <= op_dvd_next;
         op_dvs      <= op_dvs_next;
         op_tag      <= op_tag_next;
         result      <= result_next;
         drop        <= drop_next;
         ptr         <= ptr_next;
         res_valid_q <= (state_next == RESP);
         busy_q      <= (state_next != IDLE);
         issue_q     <= (state_next == ISSUE);
      end
   end

   assign res_valid    = res_valid_q;
   assign busy         = busy_q;
   assign div_valid_in = issue_q;
   assign res_quotient = result;
   assign res_tag      = op_tag;
   assign div_dividend = op_dvd;
   assign div_divisor  = op_dvs;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//
// Bench for div_issue_ctrl. A behavioural divider with a fixed 73-cycle
// latency sits on the divider port. Requests are queued per port; when one
// is accepted its expected quotient, tag and latency are pushed into a
// scoreboard, and a separate monitor pops and compares whenever a result
// handshake happens.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;

   localparam int          NUM_REQ  = 2;
   localparam int          TAG_W    = 6;
   localparam int          DIV_LAT  = 73;
   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

   typedef struct {
      logic [63:0]      dvd;
      logic [63:0]      dvs;
      logic [TAG_W-1:0] tag;
   } op_t;

   typedef struct {
      logic [63:0]      q;
      logic [TAG_W-1:0] tag;
      int               acc;
      int               lat;
   } exp_t;

   typedef struct {
      logic [63:0] dvd;
      logic [63:0] dvs;
      int          acc;
   } iss_t;

   logic                     clk;
   logic                     rst;
   logic                     flush;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*64-1:0]    req_dividend;
   logic [NUM_REQ*64-1:0]    req_divisor;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic                     res_valid;
   logic                     res_ready;
   logic [63:0]              res_quotient;
   logic [TAG_W-1:0]         res_tag;
   logic                     busy;
   logic [63:0]              div_dividend;
   logic [63:0]              div_divisor;
   logic                     div_valid_in;
   logic [63:0]              div_quotient;
   logic                     div_valid_out;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   op_t  pend [NUM_REQ][$];
   exp_t exp_q [$];
   iss_t iss_q [$];
   int   grant_log [$];

   int   last_grant = NUM_REQ - 1;
   bit   in_flight = 0;
   bit   drop_pend = 0;
   bit   rr_rand = 0;
   int   last_acc = 0;
   int   last_vout = -100;
   int   last_hs = -100;

   int   dcnt;
   logic [63:0] dq;

   div_issue_ctrl #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .req_tag       (req_tag),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_quotient  (res_quotient),
      .res_tag       (res_tag),
      .busy          (busy),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_valid_in  (div_valid_in),
      .div_quotient  (div_quotient),
      .div_valid_out (div_valid_out)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter, advanced on each rising edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Behavioural divider: the completion pulse appears 73 cycles after the
   // cycle in which div_valid_in was high.
   always @(posedge clk) begin
      if (rst) begin
         dcnt <= 0;
         dq   <= '0;
      end else if (div_valid_in) begin
         dcnt <= DIV_LAT;
         dq   <= (div_divisor == 64'd0) ? ALL_ONES
                 : 64'($signed(div_dividend) / $signed(div_divisor));
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
      end
   end

   assign div_valid_out = (dcnt == 1);
   assign div_quotient  = dq;

   // Watchdog so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit is_special(input logic [63:0] a, input logic [63:0] b);
      return (b == 64'd0) || (a == MOST_NEG && b == ALL_ONES);
   endfunction

   // Reference quotient from the arithmetic rules, truncating toward zero.
   function automatic logic [63:0] ref_quot(input logic [63:0] a, input logic [63:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (b == 64'd0) return ALL_ONES;
      if (a == MOST_NEG && b == ALL_ONES) return MOST_NEG;
      sa = a;
      sb = b;
      return sa / sb;
   endfunction

   function automatic logic [63:0] rand_operand();
      logic [63:0] v;
      v = {$urandom, $urandom};
      v = v >> $urandom_range(0, 62);
      if ($urandom_range(0, 1) == 1) v = -v;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic apply_stimulus(input int port, input logic [63:0] dvd,
                                 input logic [63:0] dvs, input logic [TAG_W-1:0] tag);
      op_t o;
      o.dvd = dvd;
      o.dvs = dvs;
      o.tag = tag;
      pend[port].push_back(o);
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_accept(input int port, input int budget);
      int n;
      n = 0;
      while (pend[port].size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      #3;
      check_output("accept_timeout", 64'(n < budget), 64'd1);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      bit any;
      n = 0;
      any = 1'b1;
      while (any && n < budget) begin
         any = in_flight || (exp_q.size() > 0);
         for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() > 0) any = 1'b1;
         if (any) begin
            @(negedge clk);
            n++;
         end
      end
      #3;
      check_output("drain_timeout", 64'(n < budget), 64'd1);
   endtask

   // Request driver: presents the head of each port queue, checks req_ready
   // against the round-robin rule and records accepted operations.
   initial begin
      logic [NUM_REQ-1:0] exp_ready;
      bit                 found;
      int                 c;
      op_t                o;
      exp_t               e;
      iss_t               s;
      req_valid    = '0;
      req_dividend = '0;
      req_divisor  = '0;
      req_tag      = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && pend[i].size() > 0) begin
               req_valid[i]                = 1'b1;
               req_dividend[64*i +: 64]    = pend[i][0].dvd;
               req_divisor[64*i +: 64]     = pend[i][0].dvs;
               req_tag[TAG_W*i +: TAG_W]   = pend[i][0].tag;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
         #1;
         if (!rst) begin
            exp_ready = '0;
            found     = 1'b0;
            if (!in_flight && !flush) begin
               for (int k = 1; k <= NUM_REQ; k++) begin
                  c = (last_grant + k) % NUM_REQ;
                  if (!found && req_valid[c]) begin
                     exp_ready[c] = 1'b1;
                     found        = 1'b1;
                  end
               end
            end
            check_output("req_ready", 64'(req_ready), 64'(exp_ready));
            for (int i = 0; i < NUM_REQ; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  o          = pend[i].pop_front();
                  last_grant = i;
                  in_flight  = 1'b1;
                  last_acc   = cyc;
                  grant_log.push_back(i);
                  e.q   = ref_quot(o.dvd, o.dvs);
                  e.tag = o.tag;
                  e.acc = cyc;
                  e.lat = is_special(o.dvd, o.dvs) ? 1 : DIV_LAT + 2;
                  exp_q.push_back(e);
                  if (!is_special(o.dvd, o.dvs)) begin
                     s.dvd = o.dvd;
                     s.dvs = o.dvs;
                     s.acc = cyc;
                     iss_q.push_back(s);
                  end
               end
            end
         end
      end
   end

   // Monitor: divider start pulses, completion pulses and result handshakes.
   initial begin
      exp_t e;
      iss_t s;
      bit   prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (div_valid_in) begin
               if (iss_q.size() == 0) begin
                  check_output("unexpected_issue", 64'd1, 64'd0);
               end else begin
                  s = iss_q.pop_front();
                  check_output("issue_cycle", 64'(cyc - s.acc), 64'd1);
                  check_output("issue_dividend", div_dividend, s.dvd);
                  check_output("issue_divisor", div_divisor, s.dvs);
                  check_output("issue_spacing", 64'(cyc - last_vout >= 2), 64'd1);
               end
            end
            if (div_valid_out) begin
               last_vout = cyc;
               if (drop_pend) begin
                  drop_pend = 1'b0;
                  in_flight = 1'b0;
               end
            end
            if (res_valid) begin
               if (exp_q.size() == 0) begin
                  check_output("unexpected_result", 64'd1, 64'd0);
               end else begin
                  e = exp_q[0];
                  check_output("res_quotient", res_quotient, e.q);
                  check_output("res_tag", 64'(res_tag), 64'(e.tag));
                  if (!prev_valid) begin
                     check_output("res_latency", 64'(cyc - e.acc), 64'(e.lat));
                  end
                  if (res_ready) begin
                     void'(exp_q.pop_front());
                     in_flight = 1'b0;
                     last_hs   = cyc;
                  end
               end
            end
            prev_valid = res_valid;
         end
      end
   end

   // Random writeback backpressure when enabled.
   initial begin
      forever begin
         @(negedge clk);
         if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Main sequence.
   initial begin
      int a;
      int n;
      int port;
      int sel;
      logic [63:0] x;
      logic [63:0] y;

      rst       = 1'b1;
      flush     = 1'b0;
      res_ready = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      check_output("rst_res_valid", 64'(res_valid), 64'd0);
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_req_ready", 64'(req_ready), 64'd0);
      check_output("rst_div_valid_in", 64'(div_valid_in), 64'd0);
      check_output("rst_res_quotient", res_quotient, 64'd0);
      check_output("rst_res_tag", 64'(res_tag), 64'd0);
      check_output("rst_div_dividend", div_dividend, 64'd0);
      check_output("rst_div_divisor", div_divisor, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #3;

      $display("[TB] single request 100/7");
      apply_stimulus(0, 64'd100, 64'd7, 6'd5);
      wait_accept(0, 20);
      a = last_acc;
      wait_cycle(a + 40);
      #3;
      check_output("busy_mid_op", 64'(busy), 64'd1);
      wait_cycle(a + 76);
      #3;
      check_output("busy_after_op", 64'(busy), 64'd0);
      wait_drain(200);

      $display("[TB] signed operands");
      apply_stimulus(1, -64'sd100, 64'd7, 6'd10);
      apply_stimulus(0, 64'd100, -64'sd7, 6'd11);
      apply_stimulus(1, -64'sd100, -64'sd7, 6'd12);
      wait_drain(600);

      $display("[TB] special cases");
      apply_stimulus(1, 64'd55, 64'd0, 6'd20);
      wait_drain(50);
      apply_stimulus(0, MOST_NEG, ALL_ONES, 6'd21);
      wait_drain(50);

      // Reset while idle: the pointer returns to its initial value, so port 0
      // wins even though port 0 was the last one granted.
      @(negedge clk);
      rst = 1'b1;
      in_flight  = 1'b0;
      drop_pend  = 1'b0;
      last_grant = NUM_REQ - 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #3;

      $display("[TB] arbitration");
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(0, rand_operand(), 64'($urandom_range(1, 1000)), 6'(i));
         apply_stimulus(1, rand_operand(), -64'($urandom_range(1, 1000)), 6'(32 + i));
      end
      wait_drain(1500);
      check_output("arb_count", 64'(grant_log.size()), 64'd8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
         check_output("arb_order", 64'(grant_log[i]), 64'(i % 2));
      end

      $display("[TB] backpressure");
      res_ready = 1'b0;
      apply_stimulus(0, 64'd1000, 64'd3, 6'd30);
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      #3;
      check_output("bp_valid_timeout", 64'(n < 200), 64'd1);
      apply_stimulus(1, 64'd77, -64'sd5, 6'd31);
      repeat (20) @(negedge clk);
      res_ready = 1'b1;
      wait_accept(1, 20);
      check_output("bp_next_accept", 64'(last_acc), 64'(last_hs + 1));
      wait_drain(200);

      $display("[TB] flush during busy");
      apply_stimulus(0, 64'd123456789, 64'd1000, 6'd40);
      wait_accept(0, 20);
      a = last_acc;
      wait_cycle(a + 30);
      flush     = 1'b1;
      drop_pend = 1'b1;
      exp_q.delete();
      @(negedge clk);
      flush = 1'b0;
      #3;
      apply_stimulus(0, -64'sd999, 64'd4, 6'd41);
      wait_accept(0, 200);
      check_output("flush_next_accept", 64'(last_acc), 64'(last_vout + 1));
      wait_drain(200);

      $display("[TB] random traffic");
      rr_rand = 1'b1;
      for (int i = 0; i < 24; i++) begin
         port = $urandom_range(0, NUM_REQ - 1);
         sel  = $urandom_range(0, 7);
         if (sel == 0) begin
            x = rand_operand();
            y = 64'd0;
         end else if (sel == 1) begin
            x = MOST_NEG;
            y = ALL_ONES;
         end else begin
            x = rand_operand();
            y = rand_operand();
         end
         apply_stimulus(port, x, y, 6'($urandom));
      end
      wait_drain(6000);
      rr_rand = 1'b0;
      @(negedge clk);
      res_ready = 1'b1;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
